if_prefetch_unit: RTL

Instruction-fetch front end placed directly upstream of `pipelined_processor`. It drives the program-memory address, captures returned instruction words into a small prefetch FIFO tagged with their PC, and presents them to decode through a valid/ready handshake. Control-flow redirects flush the FIFO and kill in-flight fetches. This decouples memory latency from decode stalls.

---
 rtl/if_pkg.sv | 19 +
 rtl/if_fifo.sv | 57 +++++
 rtl/if_prefetch_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end.
// States, FIFO entry layout and default sizes.
package if_pkg;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of PC-tagged instruction words.
// Extra wrap bit on the pointers separates full from empty.
module if_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = if_pkg::DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW + 1)'(DEPTH));
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and storage update; flush discards everything queued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch front end: sequential PC, credit-limited requests,
// redirect flush/kill and a PC-tagged prefetch FIFO to decode.
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN     = if_pkg::XLEN,
    parameter int              DEPTH    = if_pkg::DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    if_state_e       state_q;
    if_state_e       state_d;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic            inflight;
    logic            resp_kill;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occ;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    fetch_entry_t    wentry;
    fetch_entry_t    head;
    logic            unused_bits;

    // Credits come from registered occupancy only, never the pop.
    assign occ      = count + CW'(inflight);
    assign imem_req = (state_q == RUN) && !halt && !redirect_valid
                      && (occ < CW'(DEPTH));
    assign imem_addr = fetch_pc;
    assign pc        = fetch_pc;

    // A response landing in a redirect cycle belongs to the old path.
    assign resp_kill = inflight && redirect_valid;
    assign push      = inflight && !resp_kill;
    assign pop       = id_valid && id_ready;

    assign wentry.pc    = resp_pc;
    assign wentry.instr = imem_rdata;

    assign id_valid = !empty;
    assign id_instr = head.instr;
    assign id_pc    = head.pc;

    assign unused_bits = ^{full, redirect_pc[1:0]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one boot cycle, then follow the halt level.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (halt) state_d = HALT;
            HALT:    if (!halt) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    // Fetch PC, response tag and in-flight tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= imem_req;
            unique case (1'b1)
                redirect_valid: begin
                    fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
                end
                imem_req: begin
                    resp_pc  <= fetch_pc;
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                default: ;
            endcase
        end
    end

    if_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect_valid),
        .wdata(wentry),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(count)
    );

endmodule
